// File: rtl/gptp_pkg.sv
// Shared gPTP frame layout, message types and timestamp format for the Sync initiator.
// Byte k of a frame sits at bits [gptp_byte_msb(k) -: 8], byte 0 being the most significant.
package gptp_pkg;

    localparam int FRAME_W = 352;
    localparam int TS_W    = 80;
    localparam int SEQ_HI  = 111;
    localparam int TS_HI   = 79;

    localparam logic [3:0]  MSG_SYNC      = 4'h0;
    localparam logic [3:0]  MSG_FOLLOW_UP = 4'h8;
    localparam logic [31:0] NS_PER_SEC    = 32'd1000000000;

    typedef struct packed {
        logic [15:0] epoch;
        logic [31:0] sec;
        logic [31:0] ns;
    } ts_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC_TX,
        ST_SYNC_TS,
        ST_FUP_TX,
        ST_RX_WAIT,
        ST_CALC,
        ST_WAIT_INT
    } state_t;

    function automatic int gptp_byte_msb(input int k);
        return FRAME_W - 1 - 8 * k;
    endfunction

endpackage

// File: rtl/gptp_ts_diff.sv
// Link delay t2-t1 in ns; handles a single-second rollover, flags t2<t1 and saturates larger gaps.
// Latency: combinational. Backpressure: none.
// Assumes both ns fields are below one second.
module gptp_ts_diff
    import gptp_pkg::*;
(
    input  ts_t         t1,
    input  ts_t         t2,
    output logic [31:0] delay_ns,
    output logic        neg,
    output logic        sat
);

    logic [48:0] es1;
    logic [48:0] es2;
    logic [32:0] same_diff;
    logic [32:0] roll_diff;

    // Extra top bit keeps the +1 second comparison free of wrap-around.
    assign es1       = {1'b0, t1.epoch, t1.sec};
    assign es2       = {1'b0, t2.epoch, t2.sec};
    assign same_diff = {1'b0, t2.ns} - {1'b0, t1.ns};
    assign roll_diff = {1'b0, t2.ns} + {1'b0, NS_PER_SEC} - {1'b0, t1.ns};

    always_comb begin
        delay_ns = '0;
        neg      = 1'b0;
        sat      = 1'b0;
        if (es2 == es1) begin
            if (same_diff[32]) begin
                neg = 1'b1;
            end else begin
                delay_ns = same_diff[31:0];
            end
        end else if (es2 == es1 + 49'd1) begin
            delay_ns = roll_diff[31:0];
        end else if (es2 < es1) begin
            neg = 1'b1;
        end else begin
            sat      = 1'b1;
            delay_ns = '1;
        end
    end

endmodule

// File: rtl/gptp_sync_initiator.sv
// Periodic Sync + Follow_Up initiator; measures link delay from the returned Sync ingress stamp.
// Latency: meas_valid/meas_err one cycle after CALC; meas_timeout is decoded in the last RX_WAIT cycle.
// Backpressure: tx frame held stable until ready; rx ready only in RX_WAIT, otherwise frames wait upstream.
module gptp_sync_initiator
    import gptp_pkg::*;
#(
    parameter int unsigned SYNC_INTERVAL = 125000,
    parameter int unsigned RX_TIMEOUT    = 4096,
    parameter logic [63:0] CLOCK_ID      = 64'h0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    output logic                    gptp_ts_vaild,
    input  logic                    gptp_ts_ready,
    output logic [FRAME_W-1:0]      gptp_ts_data,
    input  logic                    gptp_ts_rv_vaild,
    input  logic [TS_W-1:0]         gptp_ts_rv_data,
    input  logic                    gptp_rv_vaild,
    output logic                    gptp_rv_ready,
    input  logic [TS_W+FRAME_W-1:0] gptp_rv_data,
    output logic                    meas_valid,
    output logic [31:0]             meas_delay_ns,
    output logic [15:0]             meas_seq,
    output logic                    meas_err,
    output logic                    meas_timeout
);

    localparam int B0_HI  = gptp_byte_msb(0);
    localparam int B1_HI  = gptp_byte_msb(1);
    localparam int B2_HI  = gptp_byte_msb(2);
    localparam int B20_HI = gptp_byte_msb(20);
    localparam int B28_HI = gptp_byte_msb(28);

    state_t      state_q, state_d;
    logic [15:0] seq_q, seq_d;
    logic [31:0] int_cnt_q, int_cnt_d;
    logic [31:0] rx_cnt_q, rx_cnt_d;
    ts_t         t1_q, t1_d;
    ts_t         t2_q, t2_d;
    logic        meas_valid_q, meas_valid_d;
    logic        meas_err_q, meas_err_d;
    logic [31:0] meas_delay_q, meas_delay_d;
    logic [15:0] meas_seq_q, meas_seq_d;

    logic [FRAME_W-1:0] tx_frame;
    logic [FRAME_W-1:0] rx_frame;
    ts_t                rx_t2;
    logic               rx_match;
    logic               timeout_hit;
    logic [31:0]        diff_delay;
    logic               diff_neg;
    logic               diff_sat;
    logic               unused_rx_bits;

    assign rx_frame       = gptp_rv_data[FRAME_W-1:0];
    assign rx_t2          = gptp_rv_data[FRAME_W +: TS_W];
    assign unused_rx_bits = ^rx_frame;
    assign rx_match       = (state_q == ST_RX_WAIT) && gptp_rv_vaild
                         && (rx_frame[B0_HI-4 -: 4] == MSG_SYNC)
                         && (rx_frame[SEQ_HI -: 16] == seq_q);
    assign timeout_hit    = (state_q == ST_RX_WAIT) && !rx_match
                         && (rx_cnt_q == 32'(RX_TIMEOUT - 1));

    gptp_ts_diff u_ts_diff (
        .t1       (t1_q),
        .t2       (t2_q),
        .delay_ns (diff_delay),
        .neg      (diff_neg),
        .sat      (diff_sat)
    );

    always_comb begin
        tx_frame = '0;
        if (state_q == ST_SYNC_TX || state_q == ST_FUP_TX) begin
            tx_frame[B0_HI -: 8]   = {4'h1, (state_q == ST_FUP_TX) ? MSG_FOLLOW_UP : MSG_SYNC};
            tx_frame[B1_HI -: 8]   = 8'h02;
            tx_frame[B2_HI -: 16]  = 16'd44;
            tx_frame[B20_HI -: 64] = CLOCK_ID;
            tx_frame[B28_HI -: 16] = 16'h0001;
            tx_frame[SEQ_HI -: 16] = seq_q;
            if (state_q == ST_FUP_TX) begin
                tx_frame[TS_HI -: TS_W] = t1_q;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        seq_d        = seq_q;
        int_cnt_d    = int_cnt_q + 32'd1;
        rx_cnt_d     = rx_cnt_q;
        t1_d         = t1_q;
        t2_d         = t2_q;
        meas_valid_d = 1'b0;
        meas_err_d   = 1'b0;
        meas_delay_d = meas_delay_q;
        meas_seq_d   = meas_seq_q;
        case (state_q)
            ST_IDLE: begin
                int_cnt_d = '0;
                if (enable) state_d = ST_SYNC_TX;
            end
            ST_SYNC_TX: if (gptp_ts_ready) state_d = ST_SYNC_TS;
            ST_SYNC_TS: begin
                if (gptp_ts_rv_vaild) begin
                    t1_d    = gptp_ts_rv_data;
                    state_d = ST_FUP_TX;
                end
            end
            ST_FUP_TX: begin
                if (gptp_ts_ready) begin
                    rx_cnt_d = '0;
                    state_d  = ST_RX_WAIT;
                end
            end
            ST_RX_WAIT: begin
                rx_cnt_d = rx_cnt_q + 32'd1;
                if (rx_match) begin
                    t2_d    = rx_t2;
                    state_d = ST_CALC;
                end else if (timeout_hit) begin
                    seq_d   = seq_q + 16'd1;
                    state_d = ST_WAIT_INT;
                end
            end
            ST_CALC: begin
                meas_seq_d = seq_q;
                if (diff_neg) begin
                    meas_err_d = 1'b1;
                end else begin
                    meas_valid_d = 1'b1;
                    meas_delay_d = diff_sat ? '1 : diff_delay;
                end
                seq_d   = seq_q + 16'd1;
                state_d = ST_WAIT_INT;
            end
            ST_WAIT_INT: begin
                // >= so an overrunning cycle starts the next one immediately.
                if (int_cnt_q >= 32'(SYNC_INTERVAL - 1)) begin
                    int_cnt_d = '0;
                    state_d   = enable ? ST_SYNC_TX : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            seq_q        <= '0;
            int_cnt_q    <= '0;
            rx_cnt_q     <= '0;
            t1_q         <= '0;
            t2_q         <= '0;
            meas_valid_q <= 1'b0;
            meas_err_q   <= 1'b0;
            meas_delay_q <= '0;
            meas_seq_q   <= '0;
        end else begin
            state_q      <= state_d;
            seq_q        <= seq_d;
            int_cnt_q    <= int_cnt_d;
            rx_cnt_q     <= rx_cnt_d;
            t1_q         <= t1_d;
            t2_q         <= t2_d;
            meas_valid_q <= meas_valid_d;
            meas_err_q   <= meas_err_d;
            meas_delay_q <= meas_delay_d;
            meas_seq_q   <= meas_seq_d;
        end
    end

    assign gptp_ts_vaild = (state_q == ST_SYNC_TX) || (state_q == ST_FUP_TX);
    assign gptp_ts_data  = tx_frame;
    assign gptp_rv_ready = (state_q == ST_RX_WAIT);
    assign meas_valid    = meas_valid_q;
    assign meas_err      = meas_err_q;
    assign meas_delay_ns = meas_delay_q;
    assign meas_seq      = meas_seq_q;
    assign meas_timeout  = timeout_hit;

endmodule

// File: tb/tb_gptp_sync_initiator.sv
// Randomized bench for gptp_sync_initiator: acts as tx sink, timestamper and rx returner,
// with frames and delays predicted from byte layout and plain ns arithmetic.
module tb_gptp_sync_initiator;
    import gptp_pkg::*;

    localparam int unsigned SI  = 300;
    localparam int unsigned RT  = 64;
    localparam logic [63:0] CID = 64'h0011_2233_4455_6677;
    localparam int M_NORMAL = 0, M_STALE = 1, M_TIMEOUT = 2, M_RESET = 3;

    logic          clk = 1'b0;
    logic          reset, enable;
    logic          gptp_ts_vaild, gptp_ts_ready;
    logic [351:0]  gptp_ts_data;
    logic          gptp_ts_rv_vaild;
    logic [79:0]   gptp_ts_rv_data;
    logic          gptp_rv_vaild, gptp_rv_ready;
    logic [431:0]  gptp_rv_data;
    logic          meas_valid, meas_err, meas_timeout;
    logic [31:0]   meas_delay_ns;
    logic [15:0]   meas_seq;

    int checks = 0, failures = 0, cyc = 0, tx_xfers = 0, exp_xfers = 0, last_start = -1;
    logic [15:0] seq_m = '0;
    logic [31:0] exp_delay = '0;
    logic [15:0] exp_seq = '0;

    gptp_sync_initiator #(.SYNC_INTERVAL(SI), .RX_TIMEOUT(RT), .CLOCK_ID(CID)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .gptp_ts_vaild(gptp_ts_vaild), .gptp_ts_ready(gptp_ts_ready), .gptp_ts_data(gptp_ts_data),
        .gptp_ts_rv_vaild(gptp_ts_rv_vaild), .gptp_ts_rv_data(gptp_ts_rv_data),
        .gptp_rv_vaild(gptp_rv_vaild), .gptp_rv_ready(gptp_rv_ready), .gptp_rv_data(gptp_rv_data),
        .meas_valid(meas_valid), .meas_delay_ns(meas_delay_ns), .meas_seq(meas_seq),
        .meas_err(meas_err), .meas_timeout(meas_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (gptp_ts_vaild && gptp_ts_ready) tx_xfers++;
    end

    task automatic chk(input string tag, input logic [351:0] obs, input logic [351:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [351:0] exp_frame(input bit fup, input logic [15:0] seq, input logic [79:0] ts);
        logic [7:0]   b [44];
        logic [351:0] f;
        logic [63:0]  cid;
        cid = CID;
        for (int k = 0; k < 44; k++) b[k] = 8'h00;
        b[0] = fup ? 8'h18 : 8'h10;
        b[1] = 8'h02;
        b[3] = 8'd44;
        for (int i = 0; i < 8; i++) b[20+i] = cid[63-8*i -: 8];
        b[29] = 8'h01;
        b[30] = seq[15:8];
        b[31] = seq[7:0];
        if (fup) for (int i = 0; i < 10; i++) b[34+i] = ts[79-8*i -: 8];
        f = '0;
        for (int k = 0; k < 44; k++) f[351-8*k -: 8] = b[k];
        return f;
    endfunction

    function automatic void ref_delay(input ts_t t1, input ts_t t2, output bit err, output logic [31:0] d);
        longint e1, e2, n1, n2, ds, x;
        e1 = {16'h0, t1.epoch, t1.sec};
        e2 = {16'h0, t2.epoch, t2.sec};
        n1 = t1.ns;
        n2 = t2.ns;
        ds = e2 - e1;
        err = 1'b0;
        d = '0;
        if (ds < 0) err = 1'b1;
        else if (ds > 1) d = 32'hFFFF_FFFF;
        else begin
            x = ds * 64'sd1000000000 + n2 - n1;
            if (x < 0) err = 1'b1;
            else d = x[31:0];
        end
    endfunction

    function automatic ts_t mk_ts(input logic [15:0] e, input logic [31:0] s, input logic [31:0] n);
        ts_t t;
        t.epoch = e; t.sec = s; t.ns = n;
        return t;
    endfunction

    function automatic ts_t rand_t1();
        return mk_ts(16'($urandom_range(1, 3)), $urandom, $urandom_range(0, 999999999));
    endfunction

    function automatic ts_t rand_t2(input ts_t t1, input int c);
        ts_t t;
        logic [47:0] es;
        es = {t1.epoch, t1.sec};
        t = t1;
        case (c)
            0: t.ns = t1.ns + $urandom_range(0, 999999999 - t1.ns);
            1: begin es = es + 48'd1; t.ns = $urandom_range(0, 999999999); end
            2: begin es = es + 48'($urandom_range(2, 5)); t.ns = $urandom_range(0, 999999999); end
            default: begin
                if (t1.ns > 0) t.ns = $urandom_range(0, t1.ns - 1);
                else begin es = es - 48'd1; t.ns = 32'd5; end
            end
        endcase
        {t.epoch, t.sec} = es;
        return t;
    endfunction

    task automatic send_tx(input string tag, input logic [351:0] exp, input int stall, input bit is_sync);
        int n;
        n = 0;
        gptp_ts_ready = (stall == 0);
        while (!gptp_ts_vaild && n < 2 * SI) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_vld"}, gptp_ts_vaild, 1'b1);
        chk({tag, "_dat"}, gptp_ts_data, exp);
        chk({tag, "_rv_rdy"}, gptp_rv_ready, 1'b0);
        if (is_sync) begin
            if (last_start >= 0) chk("interval", cyc - last_start, SI);
            last_start = cyc;
        end
        for (int i = 1; i < stall; i++) begin
            @(negedge clk);
            chk("stall_vld", gptp_ts_vaild, 1'b1);
            chk("stall_dat", gptp_ts_data, exp);
        end
        gptp_ts_ready = 1'b1;
        @(negedge clk);
        gptp_ts_ready = 1'b0;
        exp_xfers++;
        chk({tag, "_drop"}, gptp_ts_vaild, 1'b0);
        chk({tag, "_xfers"}, tx_xfers, exp_xfers);
    endtask

    task automatic rx_send(input logic [79:0] t2, input logic [351:0] frame);
        gptp_rv_vaild = 1'b1;
        gptp_rv_data  = {t2, frame};
        @(negedge clk);
        gptp_rv_vaild = 1'b0;
        gptp_rv_data  = '0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_vld"}, gptp_ts_vaild, 1'b0);
        chk({tag, "_dat"}, gptp_ts_data, '0);
        chk({tag, "_rv_rdy"}, gptp_rv_ready, 1'b0);
        chk({tag, "_mv"}, meas_valid, 1'b0);
        chk({tag, "_me"}, meas_err, 1'b0);
        chk({tag, "_mt"}, meas_timeout, 1'b0);
        chk({tag, "_delay"}, meas_delay_ns, '0);
        chk({tag, "_seq"}, meas_seq, '0);
    endtask

    task automatic run_cycle(input ts_t t1, input ts_t t2, input int mode, input int stall);
        int n;
        bit err;
        logic [31:0] d;
        send_tx("sync", exp_frame(1'b0, seq_m, '0), stall, 1'b1);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        gptp_ts_rv_vaild = 1'b1;
        gptp_ts_rv_data  = t1;
        @(negedge clk);
        gptp_ts_rv_vaild = 1'b0;
        gptp_ts_rv_data  = '0;
        send_tx("fup", exp_frame(1'b1, seq_m, t1), 0, 1'b0);
        chk("rx_rdy", gptp_rv_ready, 1'b1);
        if (mode == M_TIMEOUT) begin
            n = 1;
            while (!meas_timeout && n < 4 * RT) begin
                @(negedge clk);
                n++;
            end
            chk("timeout_cycle", n, RT);
            chk("timeout_no_meas", meas_valid, 1'b0);
            @(negedge clk);
            chk("timeout_pulse", meas_timeout, 1'b0);
            chk("timeout_rdy_drop", gptp_rv_ready, 1'b0);
            seq_m++;
        end else if (mode == M_RESET) begin
            repeat (3) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            check_outputs_zero("midrst");
            reset = 1'b0;
            seq_m = '0;
            exp_delay = '0;
            exp_seq = '0;
            last_start = -1;
        end else begin
            if (mode == M_STALE) begin
                rx_send(80'($urandom), exp_frame(1'b0, seq_m - 16'd1, '0));
                rx_send(80'($urandom), exp_frame(1'b1, seq_m, t1));
                @(negedge clk);
                chk("stale_no_meas", meas_valid | meas_err, 1'b0);
                chk("stale_still_rdy", gptp_rv_ready, 1'b1);
            end
            repeat ($urandom_range(0, 4)) @(negedge clk);
            rx_send(t2, exp_frame(1'b0, seq_m, '0));
            chk("meas_early", meas_valid, 1'b0);
            @(negedge clk);
            ref_delay(t1, t2, err, d);
            if (!err) exp_delay = d;
            exp_seq = seq_m;
            chk("meas_valid", meas_valid, !err);
            chk("meas_err", meas_err, err);
            chk("meas_delay", meas_delay_ns, exp_delay);
            chk("meas_seq", meas_seq, exp_seq);
            @(negedge clk);
            chk("meas_pulse", meas_valid | meas_err, 1'b0);
            chk("meas_hold", meas_delay_ns, exp_delay);
            seq_m++;
        end
    endtask

    initial begin
        ts_t t1;
        int seen;
        reset = 1'b1; enable = 1'b0; gptp_ts_ready = 1'b0;
        gptp_ts_rv_vaild = 1'b0; gptp_ts_rv_data = '0;
        gptp_rv_vaild = 1'b0; gptp_rv_data = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b0;
        enable = 1'b1;

        run_cycle(mk_ts(16'd0, 32'd5, 32'd100), mk_ts(16'd0, 32'd5, 32'd1100), M_NORMAL, 0);
        chk("fixed_1000", meas_delay_ns, 32'd1000);
        run_cycle(mk_ts(16'd0, 32'd7, 32'd999999900), mk_ts(16'd0, 32'd8, 32'd100), M_NORMAL, 0);
        chk("fixed_rollover", meas_delay_ns, 32'd200);
        t1 = rand_t1();
        run_cycle(t1, t1, M_TIMEOUT, 0);
        t1 = rand_t1();
        run_cycle(t1, rand_t2(t1, 3), M_NORMAL, 2);
        t1 = rand_t1();
        run_cycle(t1, rand_t2(t1, 0), M_STALE, 0);
        t1 = rand_t1();
        run_cycle(t1, rand_t2(t1, 1), M_NORMAL, 20);
        for (int i = 0; i < 8; i++) begin
            t1 = rand_t1();
            run_cycle(t1, rand_t2(t1, $urandom_range(0, 3)), M_NORMAL, $urandom_range(0, 3));
        end
        t1 = rand_t1();
        run_cycle(t1, t1, M_RESET, 0);
        t1 = rand_t1();
        run_cycle(t1, rand_t2(t1, 0), M_NORMAL, 1);

        enable = 1'b0;
        seen = 0;
        for (int i = 0; i < 2 * SI; i++) begin
            @(negedge clk);
            if (gptp_ts_vaild) seen++;
        end
        chk("idle_after_disable", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
